// File: rtl/exec_sched.sv
// exec1 issue/hazard controller: load-use bubble insertion, registered forwarding selects,
// and multi-cycle multiply sequencing. Optional stall counters under EXEC_SCHED_PERF_EN.
module exec_sched #(
  parameter int REG_ADDR = 5,
  parameter int MUL_LAT  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  input  logic [REG_ADDR-1:0] id_rs1,
  input  logic [REG_ADDR-1:0] id_rs2,
  input  logic                id_uses_rs2,
  input  logic                id_is_mul,
  input  logic [REG_ADDR-1:0] ex_dst_reg,
  input  logic                ex_regwrite,
  input  logic                ex_do_read,
  input  logic [REG_ADDR-1:0] mem_dst_reg,
  input  logic                mem_regwrite,
  output logic [1:0]          forward_src1,
  output logic [1:0]          forward_src2,
  output logic                stall_id,
  output logic                ex_bubble,
  output logic                ex_we,
  output logic                busy
`ifdef EXEC_SCHED_PERF_EN
  ,
  output logic [31:0]         perf_lu_stalls,
  output logic [31:0]         perf_mul_stalls
`endif
);

  typedef enum logic {IDLE = 1'b0, MUL_BUSY = 1'b1} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);
  localparam logic [1:0] SEL_REG  = 2'd0;
  localparam logic [1:0] SEL_MEM  = 2'd1;
  localparam logic [1:0] SEL_WB   = 2'd2;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  fwd1_q, fwd1_d;
  logic [1:0]  fwd2_q, fwd2_d;

  logic rs1_ex, rs2_ex, rs1_mem, rs2_mem, load_use;

  function automatic logic src_match(input logic [REG_ADDR-1:0] rs,
                                     input logic [REG_ADDR-1:0] dst,
                                     input logic                wr);
    return wr && (dst != '0) && (rs == dst);
  endfunction

  // The youngest producer (the instruction now in ID/EX) wins over the older one.
  function automatic logic [1:0] fwd_sel(input logic hit_ex, input logic hit_mem);
    if (hit_ex)       return SEL_MEM;
    else if (hit_mem) return SEL_WB;
    else              return SEL_REG;
  endfunction

  always_comb begin
    rs1_ex   = src_match(id_rs1, ex_dst_reg, ex_regwrite);
    rs2_ex   = id_uses_rs2 && src_match(id_rs2, ex_dst_reg, ex_regwrite);
    rs1_mem  = src_match(id_rs1, mem_dst_reg, mem_regwrite);
    rs2_mem  = id_uses_rs2 && src_match(id_rs2, mem_dst_reg, mem_regwrite);
    load_use = id_valid && ex_do_read && (rs1_ex || rs2_ex);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fwd1_q  <= SEL_REG;
      fwd2_q  <= SEL_REG;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fwd1_q  <= fwd1_d;
      fwd2_q  <= fwd2_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fwd1_d  = fwd1_q;
    fwd2_d  = fwd2_q;
    unique case (state_q)
      IDLE: begin
        fwd1_d = SEL_REG;
        fwd2_d = SEL_REG;
        if (id_valid && !load_use) begin
          fwd1_d = fwd_sel(rs1_ex, rs1_mem);
          fwd2_d = fwd_sel(rs2_ex, rs2_mem);
          if (id_is_mul) begin
            state_d = MUL_BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      MUL_BUSY: begin
        // Selects stay put so the operand muxes keep feeding the multiplier.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_id  = 1'b0;
    ex_bubble = 1'b0;
    ex_we     = 1'b1;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        stall_id  = load_use;
        ex_bubble = load_use;
      end
      MUL_BUSY: begin
        stall_id = 1'b1;
        ex_we    = 1'b0;
        busy     = 1'b1;
      end
      default: ;
    endcase
  end

  assign forward_src1 = fwd1_q;
  assign forward_src2 = fwd2_q;

`ifdef EXEC_SCHED_PERF_EN
  logic [31:0] lu_cnt_q, lu_cnt_d;
  logic [31:0] mul_cnt_q, mul_cnt_d;

  always_comb begin
    lu_cnt_d  = lu_cnt_q;
    mul_cnt_d = mul_cnt_q;
    if ((state_q == IDLE) && load_use && (lu_cnt_q != 32'hFFFF_FFFF))
      lu_cnt_d = lu_cnt_q + 32'd1;
    if ((state_q == MUL_BUSY) && (mul_cnt_q != 32'hFFFF_FFFF))
      mul_cnt_d = mul_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      lu_cnt_q  <= '0;
      mul_cnt_q <= '0;
    end else begin
      lu_cnt_q  <= lu_cnt_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end

  assign perf_lu_stalls  = lu_cnt_q;
  assign perf_mul_stalls = mul_cnt_q;
`endif

endmodule
